// File: rtl/alu_mul_seq.sv
// Sequential shift-and-add multiplier: one WIDTH-bit ripple adder reused over WIDTH cycles.
// Optional two's-complement mode when SIGNED_MUL_EN is defined.

module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module alu_mul_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mcand, mq, acc;
    logic [CW-1:0]    cnt;
    logic             last;
    logic [WIDTH-1:0] add_b, sum;
    logic [WIDTH:0]   c;
    logic             msb_in;

    assign last = (cnt == CW'(WIDTH - 1));

`ifdef SIGNED_MUL_EN
    // Final iteration weights the multiplier sign bit negatively, so it subtracts.
    logic sub;
    assign sub    = last & mq[0];
    assign add_b  = (mq[0] ? mcand : '0) ^ {WIDTH{sub}};
    assign c[0]   = sub;
    assign msb_in = sum[WIDTH-1] ^ c[WIDTH] ^ c[WIDTH-1];
`else
    assign add_b  = mq[0] ? mcand : '0;
    assign c[0]   = 1'b0;
    assign msb_in = c[WIDTH];
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .x  (acc[i]),
            .y  (add_b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mq      <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            if (state == IDLE && start) begin
                mcand <= a;
                mq    <= b;
                acc   <= '0;
                cnt   <= '0;
            end else if (state == RUN) begin
                acc <= {msb_in, sum[WIDTH-1:1]};
                mq  <= {sum[0], mq[WIDTH-1:1]};
                cnt <= cnt + 1'b1;
                if (last) product <= {msb_in, sum, mq[WIDTH-1:1]};
            end
        end
    end
endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: a cycle-level timing model plus a*b arithmetic reference.
// Build with +define+SIGNED_MUL_EN to exercise the signed mode.

module tb_alu_mul_seq;
    localparam int W  = 4;
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  a, b;
    logic          busy, done;
    logic [PW-1:0] product;

    alu_mul_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    int            checks   = 0;
    int            failures = 0;
    logic [PW-1:0] sb_q[$];
    int            cyc      = 0;
    int            k        = 0;
    bit            have_k   = 1'b0;
    logic [PW-1:0] pend     = '0;
    logic [PW-1:0] exp_prod = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        int sx, sy;
        sx = int'(x);
        sy = int'(y);
`ifdef SIGNED_MUL_EN
        if (x[W-1]) sx -= (1 << W);
        if (y[W-1]) sy -= (1 << W);
`endif
        return PW'(sx * sy);
    endfunction

    // Reference: a start accepted on edge k gives busy after edges k..k+W-1,
    // done after edge k+W, and the next start is accepted no earlier than edge k+W+2.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q.delete();
            have_k   = 1'b0;
            exp_prod = '0;
        end else begin
            cyc++;
            if (have_k && cyc == k + W) exp_prod = pend;
            if (start && (!have_k || cyc >= k + W + 2)) begin
                k      = cyc;
                have_k = 1'b1;
                pend   = ref_mul(a, b);
                sb_q.push_back(pend);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", 32'(busy), 32'(have_k && cyc >= k && cyc <= k + W - 1));
            check("done", 32'(done), 32'(have_k && cyc == k + W));
            check("product_hold", 32'(product), 32'(exp_prod));
            if (done) begin
                if (sb_q.size() == 0) check("done_unexpected", 32'(done), 32'd0);
                else                  check("product", 32'(product), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic txn(input logic [W-1:0] x, input logic [W-1:0] y, input bit noise);
        @(negedge clk);
        start = 1'b1;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < W + 1; i++) begin
            if (noise) begin
                a     = W'($urandom);
                b     = W'($urandom);
                start = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        #1 rst_n = 1'b1;

`ifdef SIGNED_MUL_EN
        txn(4'd8, 4'd8, 1'b0);
        txn(4'd13, 4'd5, 1'b0);
        txn(4'd7, 4'd8, 1'b0);
        txn(4'd15, 4'd15, 1'b0);
`endif
        txn(4'd15, 4'd15, 1'b0);
        txn(4'd13, 4'd11, 1'b0);
        txn(4'd0, 4'd12, 1'b0);
        txn(4'd12, 4'd0, 1'b0);
        txn(4'd6, 4'd6, 1'b1);

        // Continuous start re-triggers at the minimum interval.
        @(negedge clk);
        start = 1'b1;
        a     = 4'd2;
        b     = 4'd3;
        repeat (3 * (W + 2)) @(negedge clk);
        start = 1'b0;
        repeat (W + 3) @(negedge clk);

        // Asynchronous reset part-way through RUN.
        start = 1'b1;
        a     = 4'd9;
        b     = 4'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset_busy", 32'(busy), 32'd0);
        check("midrun_reset_done", 32'(done), 32'd0);
        check("midrun_reset_product", 32'(product), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        txn(4'd3, 4'd5, 1'b0);

        repeat (20) txn(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));

        start = 1'b0;
        repeat (W + 4) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
Sequential shift-and-add multiplier controller for the 4-bit ALU. It owns one WIDTH-bit ripple-carry add/subtract datapath:
- built from the team's full-adder cell;
- op=1 inverts B and forces carry-in to 1.

Over WIDTH clock cycles it sequences that adder to form a 2*WIDTH-bit product. It sits beside the ALU's add/sub path and uses a start/busy/done handshake toward the ALU op decoder.

Parameters:
WIDTH, 4, operand width in bits; product is 2*WIDTH bits; legal range 2..8.

Ports:
clk  input  1  single clock; all state changes on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  multiplicand; captured on the accepted start edge
b  input  WIDTH  multiplier; captured on the accepted start edge
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when product becomes valid
product  output  2*WIDTH  result; held stable from done until the next accepted start

Behaviour:
- Reset: asserting rst_n low immediately forces the following, regardless of state (including mid-RUN):
  - state=IDLE;
  - busy=0, done=0, product=0;
  - accumulator, multiplier register and iteration counter cleared.
- State machine has three states: IDLE, RUN, DONE.
- IDLE:
  - start=1 on an edge captures a into MCAND and b into MQ;
  - clears ACC (WIDTH bits), the carry bit and CNT;
  - next state RUN.
  - start=0: stay in IDLE.
- RUN, once per cycle:
  - Adder inputs are ACC and MCAND. Adder op=0 (add) when MQ[0]=1; when MQ[0]=0, B input is gated to 0.
  - Then {carry, sum, MQ} shifts right by 1 into {ACC, MQ}, with carry-out becoming the new ACC MSB.
  - CNT increments.
  - When CNT reaches WIDTH-1 on this edge: next state DONE, product <= {shifted ACC, shifted MQ}.
- DONE:
  - done=1 for exactly one cycle; next state IDLE.
  - product is unchanged until the next accepted start.
- Latency:
  - The start-sampling edge is edge 0; RUN occupies edges 1..WIDTH.
  - done is high in the cycle after edge WIDTH, i.e. WIDTH+1 clocks after start.
  - Minimum start-to-start interval is WIDTH+2 cycles.
- busy=1 exactly in RUN (WIDTH cycles). busy and done are never high together.
- start in RUN or DONE is ignored (no queueing). start held continuously re-triggers on the first IDLE edge after DONE.
- a and b may change freely after the capture edge without affecting the result.
- product is updated only on the final RUN edge; it is never partially visible.
- Unsigned arithmetic: product = a*b exactly; cannot overflow 2*WIDTH bits.
- Boundary cases: a=0 or b=0 gives product 0. a=b=all-ones gives the maximum value (WIDTH=4: 225).

Optional Feature:
SIGNED_MUL_EN
- Defined: a and b are two's complement.
  - Iterations 0..WIDTH-2 add MCAND when MQ[0]=1.
  - The final iteration (CNT=WIDTH-1) subtracts MCAND (adder op=1) when MQ[0]=1.
  - The shifted-in MSB is the true sign of the (WIDTH+1)-bit result, computed as sum MSB XOR adder overflow (carry into MSB XOR carry out), not the carry-out.
  - product is the two's complement 2*WIDTH-bit a*b. Latency and handshake are identical to unsigned mode.
- Undefined: unsigned only as above. The subtract path and overflow logic are not synthesized.

Test Plan:
- Reset mid-RUN: start a=9,b=7, pull rst_n low after 2 RUN cycles -> busy=0, done=0, product=0 immediately, without waiting for a clock edge; after release, start a=3,b=5 -> product=0x0F.
- Unsigned WIDTH=4: a=15,b=15, start high 1 cycle -> busy high exactly 4 cycles; done pulses 5 clocks after the start edge; product=0xE1. Also a=13,b=11 -> 0x8F.
- Zero operands: a=0,b=12 -> 0x00; a=12,b=0 -> 0x00; done timing unchanged.
- Handshake: hold start high continuously with a=2,b=3 -> done pulses every 6 cycles with product=0x06.
- Handshake: pulse start during RUN with different operands -> ignored, product from the original operands.
- Operand stability: change a and b every cycle during RUN after capturing a=6,b=6 -> product=0x24.
- SIGNED_MUL_EN defined:
  - a=-8,b=-8 -> 0x40
  - a=-3,b=5 -> 0xF1
  - a=7,b=-8 -> 0xC8
  - a=-1,b=-1 -> 0x01
